cm_arb_req_gen: RTL and testbench

//  Per-master input stage of the AHB-Lite matrix; the producing end of the arbiter's req/pri interface.

---
 rtl/cm_ahb_pkg.sv | 16 +
 rtl/cm_arb_req_buf.sv | 42 ++++
 rtl/cm_arb_req_gen.sv | 140 ++++++++++++++
 tb/tb_cm_arb_req_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_ahb_pkg.sv
// AHB-Lite encodings shared by the matrix input stages, plus the request
// generator's state type.
package cm_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DPH  = 2'd2
  } req_state_e;

endpackage

// File: rtl/cm_arb_req_buf.sv
// One-entry address-phase holding register with a valid flag; capture wins
// over clear, and reset discards whatever was held.
module cm_arb_req_buf #(
  parameter int WIDTH = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/cm_arb_req_gen.sv
// Per-master input stage of the AHB-Lite matrix: raises req/pri towards the
// arbiter, parks one un-granted address phase and stalls the master until it goes.
module cm_arb_req_gen
  import cm_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PRI_WIDTH  = 1,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL_m,
  input  logic [1:0]            HTRANS_m,
  input  logic [ADDR_WIDTH-1:0] HADDR_m,
  input  logic                  HWRITE_m,
  input  logic [2:0]            HSIZE_m,
  input  logic [2:0]            HBURST_m,
  input  logic [3:0]            HPROT_m,
  input  logic                  HMASTLOCK_m,
  input  logic                  HREADY_m,
  output logic                  HREADYOUT_m,
  output logic                  HRESP_m,
  input  logic [PRI_WIDTH-1:0]  pri_cfg,
  output logic                  req,
  output logic [PRI_WIDTH-1:0]  pri,
  input  logic                  gnt,
  output logic [1:0]            o_trans,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_write,
  output logic [2:0]            o_size,
  output logic [2:0]            o_burst,
  output logic [3:0]            o_prot,
  output logic                  o_lock,
  input  logic                  o_ready,
  input  logic                  o_resp
);

  localparam int AW = (AGE_WIDTH > 0) ? AGE_WIDTH : 1;
  localparam int PW = ADDR_WIDTH + 14;

  req_state_e      state_q, state_d;
  logic            hold_q, hold_d;
  logic [AW-1:0]   age_cnt_q, age_cnt_d;

  logic            v_now, accept, capture, buf_clear, buf_valid;
  logic [PW-1:0]   master_phase, buf_phase, fwd_phase;
  logic [1:0]      fwd_trans;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic            fwd_write, fwd_lock;
  logic [2:0]      fwd_size, fwd_burst;
  logic [3:0]      fwd_prot;

  assign v_now  = HSEL_m & HTRANS_m[1] & HREADY_m;
  assign accept = gnt & o_ready;

  assign master_phase = {HTRANS_m, HADDR_m, HWRITE_m, HSIZE_m, HBURST_m, HPROT_m, HMASTLOCK_m};
  assign capture      = (state_q != ST_PEND) & v_now & ~accept;
  assign buf_clear    = (state_q == ST_PEND) & accept;

  cm_arb_req_buf #(.WIDTH(PW)) u_buf (
    .clk     (HCLK),
    .rst     (HRESET),
    .capture (capture),
    .clear   (buf_clear),
    .d       (master_phase),
    .valid   (buf_valid),
    .q       (buf_phase)
  );

  assign fwd_phase = buf_valid ? buf_phase : master_phase;
  assign {fwd_trans, fwd_addr, fwd_write, fwd_size, fwd_burst, fwd_prot, fwd_lock} = fwd_phase;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PEND: if (accept) state_d = ST_DPH;
      ST_DPH: begin
        if (v_now)        state_d = accept ? ST_DPH : ST_PEND;
        else if (o_ready) state_d = ST_IDLE;
      end
      default: if (v_now) state_d = accept ? ST_DPH : ST_PEND;
    endcase
  end

  // A new burst or locked beat takes priority over the unlocking condition.
  always_comb begin
    hold_d = hold_q;
    if (accept) begin
      if (fwd_trans != HTRANS_IDLE && (fwd_lock || fwd_burst != HBURST_SINGLE))
        hold_d = 1'b1;
      else if (!fwd_lock && (fwd_trans == HTRANS_IDLE || fwd_trans == HTRANS_NONSEQ))
        hold_d = 1'b0;
    end
  end

  always_comb begin
    age_cnt_d = age_cnt_q;
    if (state_q != ST_PEND || accept)
      age_cnt_d = '0;
    else if (AGE_WIDTH > 0 && !gnt && age_cnt_q != {AW{1'b1}})
      age_cnt_d = age_cnt_q + 1'b1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      hold_q    <= 1'b0;
      age_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      age_cnt_q <= age_cnt_d;
    end
  end

  always_comb begin
    HREADYOUT_m = 1'b1;
    HRESP_m     = 1'b0;
    case (state_q)
      ST_PEND: HREADYOUT_m = 1'b0;
      ST_DPH: begin
        HREADYOUT_m = o_ready;
        HRESP_m     = o_resp;
      end
      default: ;
    endcase
  end

  // Master-side inputs may still be live during reset, so gate the arbiter view.
  assign req     = ~HRESET & (buf_valid | v_now | hold_q);
  assign pri     = (AGE_WIDTH > 0 && age_cnt_q == {AW{1'b1}}) ? {PRI_WIDTH{1'b1}} : pri_cfg;
  assign o_trans = (gnt & ~HRESET) ? fwd_trans : HTRANS_IDLE;
  assign o_addr  = fwd_addr;
  assign o_write = fwd_write;
  assign o_size  = fwd_size;
  assign o_burst = fwd_burst;
  assign o_prot  = fwd_prot;
  assign o_lock  = fwd_lock;

endmodule

// File: tb/tb_cm_arb_req_gen.sv
// Self-checking bench for cm_arb_req_gen: directed vector table, async reset
// while stalled, and randomized traffic against a transaction-level model.
module tb_cm_arb_req_gen;

  localparam logic       H  = 1'b1;
  localparam logic       L  = 1'b0;
  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] BS = 3'b000;
  localparam logic [2:0] I4 = 3'b011;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL_m, HWRITE_m, HMASTLOCK_m, HREADY_m, gnt, o_ready, o_resp;
  logic [1:0]  HTRANS_m;
  logic [31:0] HADDR_m;
  logic [2:0]  HSIZE_m, HBURST_m;
  logic [3:0]  HPROT_m;
  logic [0:0]  pri_cfg;
  logic        HREADYOUT_m, HRESP_m, req, o_write, o_lock;
  logic [0:0]  pri;
  logic [1:0]  o_trans;
  logic [31:0] o_addr;
  logic [2:0]  o_size, o_burst;
  logic [3:0]  o_prot;

  cm_arb_req_gen #(.ADDR_WIDTH(32), .PRI_WIDTH(1), .AGE_WIDTH(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_m(HSEL_m), .HTRANS_m(HTRANS_m),
    .HADDR_m(HADDR_m), .HWRITE_m(HWRITE_m), .HSIZE_m(HSIZE_m), .HBURST_m(HBURST_m),
    .HPROT_m(HPROT_m), .HMASTLOCK_m(HMASTLOCK_m), .HREADY_m(HREADY_m),
    .HREADYOUT_m(HREADYOUT_m), .HRESP_m(HRESP_m), .pri_cfg(pri_cfg), .req(req),
    .pri(pri), .gnt(gnt), .o_trans(o_trans), .o_addr(o_addr), .o_write(o_write),
    .o_size(o_size), .o_burst(o_burst), .o_prot(o_prot), .o_lock(o_lock),
    .o_ready(o_ready), .o_resp(o_resp)
  );

  always #5 HCLK = ~HCLK;

  // One bench cycle: master/downstream inputs plus the outputs they must produce.
  typedef struct {
    logic        hsel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic        lock;
    logic        hready;
    logic        gnt;
    logic        ordy;
    logic        oresp;
    logic        e_hro;
    logic        e_resp;
    logic        e_req;
    logic        e_pri;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        chk_addr;
    logic [2:0]  e_burst;
    logic        e_lock;
  } vec_t;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic        lock;
  } aph_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[19];

  // Reference model: waiting address phases, outstanding data phase, locked
  // sequence in progress, and how many cycles the waiting phase went ungranted.
  aph_t pend[$];
  logic in_dph;
  logic locked_seq;
  int   starve;

  task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    HSEL_m      = v.hsel;
    HTRANS_m    = v.trans;
    HADDR_m     = v.addr;
    HBURST_m    = v.burst;
    HMASTLOCK_m = v.lock;
    HREADY_m    = v.hready;
    gnt         = v.gnt;
    o_ready     = v.ordy;
    o_resp      = v.oresp;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    cmp(tag, "HREADYOUT_m", 32'(HREADYOUT_m), 32'(v.e_hro));
    cmp(tag, "HRESP_m", 32'(HRESP_m), 32'(v.e_resp));
    cmp(tag, "req", 32'(req), 32'(v.e_req));
    cmp(tag, "pri", 32'(pri), 32'(v.e_pri));
    cmp(tag, "o_trans", 32'(o_trans), 32'(v.e_trans));
    if (v.chk_addr) cmp(tag, "o_addr", o_addr, v.e_addr);
    cmp(tag, "o_burst", 32'(o_burst), 32'(v.e_burst));
    cmp(tag, "o_lock", 32'(o_lock), 32'(v.e_lock));
    cmp(tag, "o_write/size/prot", 32'({o_write, o_size, o_prot}), 32'({1'b1, 3'b010, 4'b0011}));
  endtask

  task automatic runRow(input string tag, input vec_t v);
    applyStimulus(v);
    #2;
    checkOutput(tag, v);
    @(posedge HCLK);
    #1;
  endtask

  function automatic vec_t modelExpect(input vec_t v);
    vec_t r;
    aph_t f;
    logic busy;
    r    = v;
    busy = (pend.size() != 0);
    if (busy) f = pend[0];
    else begin
      f.trans = v.trans; f.addr = v.addr; f.burst = v.burst; f.lock = v.lock;
    end
    r.e_hro    = busy ? L : (in_dph ? v.ordy : H);
    r.e_resp   = (!busy && in_dph) ? v.oresp : L;
    r.e_req    = busy || (v.hsel && v.trans[1] && v.hready) || locked_seq;
    r.e_pri    = (starve >= 3) ? H : pri_cfg[0];
    r.e_trans  = v.gnt ? f.trans : TI;
    r.e_addr   = f.addr;
    r.chk_addr = H;
    r.e_burst  = f.burst;
    r.e_lock   = f.lock;
    return r;
  endfunction

  task automatic modelStep(input vec_t v);
    aph_t f;
    logic acc, vn;
    acc = v.gnt && v.ordy;
    vn  = v.hsel && v.trans[1] && v.hready;
    if (pend.size() != 0) f = pend[0];
    else begin
      f.trans = v.trans; f.addr = v.addr; f.burst = v.burst; f.lock = v.lock;
    end
    if (acc) begin
      if (f.trans != TI && (f.lock || f.burst != BS)) locked_seq = H;
      else if (!f.lock && (f.trans == TI || f.trans == NS)) locked_seq = L;
    end
    if (pend.size() != 0) begin
      if (acc) begin
        pend.delete(0);
        in_dph = H;
        starve = 0;
      end else if (!v.gnt) begin
        starve++;
      end
    end else begin
      starve = 0;
      if (vn) begin
        if (acc) in_dph = H;
        else begin
          pend.push_back(f);
          in_dph = L;
        end
      end else if (in_dph && v.ordy) begin
        in_dph = L;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v, r;

    //            hsel trans addr      burst lock rdy gnt ordy resp | hro resp req pri trans addr chk burst lock
    tbl[0]  = '{H, NS, 32'h100, BS, L, H, H, H, L,  H, L, H, L, NS, 32'h100, H, BS, L};
    tbl[1]  = '{L, TI, 32'h000, BS, L, H, H, H, L,  H, L, L, L, TI, 32'h000, L, BS, L};
    tbl[2]  = '{H, NS, 32'h200, BS, L, H, L, H, L,  H, L, H, L, TI, 32'h200, H, BS, L};
    tbl[3]  = '{H, NS, 32'h200, BS, L, L, L, H, L,  L, L, H, L, TI, 32'h200, H, BS, L};
    tbl[4]  = '{H, NS, 32'h200, BS, L, L, L, H, L,  L, L, H, L, TI, 32'h200, H, BS, L};
    tbl[5]  = '{H, NS, 32'h200, BS, L, L, L, H, L,  L, L, H, L, TI, 32'h200, H, BS, L};
    tbl[6]  = '{H, NS, 32'h300, BS, L, L, H, H, L,  L, L, H, H, NS, 32'h200, H, BS, L};
    tbl[7]  = '{L, TI, 32'h000, BS, L, H, H, H, L,  H, L, L, L, TI, 32'h000, L, BS, L};
    tbl[8]  = '{H, NS, 32'h400, I4, H, H, H, H, L,  H, L, H, L, NS, 32'h400, H, I4, H};
    tbl[9]  = '{H, SQ, 32'h404, I4, H, H, H, H, L,  H, L, H, L, SQ, 32'h404, H, I4, H};
    tbl[10] = '{H, BZ, 32'h408, I4, H, H, H, H, L,  H, L, H, L, BZ, 32'h408, H, I4, H};
    tbl[11] = '{H, SQ, 32'h408, I4, H, H, H, H, L,  H, L, H, L, SQ, 32'h408, H, I4, H};
    tbl[12] = '{H, SQ, 32'h40C, I4, H, H, H, H, L,  H, L, H, L, SQ, 32'h40C, H, I4, H};
    tbl[13] = '{H, TI, 32'h000, BS, L, H, H, H, L,  H, L, H, L, TI, 32'h000, L, BS, L};
    tbl[14] = '{H, TI, 32'h000, BS, L, H, H, H, L,  H, L, L, L, TI, 32'h000, L, BS, L};
    tbl[15] = '{H, NS, 32'h500, BS, L, H, H, H, L,  H, L, H, L, NS, 32'h500, H, BS, L};
    tbl[16] = '{H, NS, 32'h504, BS, L, L, H, L, H,  L, H, L, L, NS, 32'h504, H, BS, L};
    tbl[17] = '{H, TI, 32'h000, BS, L, H, H, H, H,  H, H, L, L, TI, 32'h000, L, BS, L};
    tbl[18] = '{H, TI, 32'h000, BS, L, H, H, H, L,  H, L, L, L, TI, 32'h000, L, BS, L};

    HWRITE_m = 1'b1;
    HSIZE_m  = 3'b010;
    HPROT_m  = 4'b0011;

    // Reset with a live, granted master: arbiter side must still look idle.
    $display("[TB] reset state");
    HRESET  = 1'b1;
    pri_cfg = 1'b1;
    v = '{H, NS, 32'h700, BS, L, H, H, H, L,  H, L, L, H, TI, 32'h700, H, BS, L};
    applyStimulus(v);
    #2;
    checkOutput("reset", v);
    @(posedge HCLK);
    #1;
    pri_cfg = 1'b0;
    HRESET  = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 19; i++) runRow($sformatf("vec%0d", i), tbl[i]);

    $display("[TB] reset while an address phase is parked");
    runRow("pendA", '{H, NS, 32'h600, BS, L, H, L, H, L,  H, L, H, L, TI, 32'h600, H, BS, L});
    v = '{H, NS, 32'h600, BS, L, L, L, H, L,  L, L, H, L, TI, 32'h600, H, BS, L};
    applyStimulus(v);
    #2;
    checkOutput("pendB", v);
    HRESET = 1'b1;
    v = '{L, TI, 32'h000, BS, L, H, H, L, L,  H, L, L, L, TI, 32'h000, H, BS, L};
    applyStimulus(v);
    #1;
    checkOutput("rstAsync", v);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    runRow("postRst0", v);
    runRow("postRst1", v);

    $display("[TB] randomized traffic against model");
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    pend.delete();
    in_dph     = L;
    locked_seq = L;
    starve     = 0;
    for (int i = 0; i < 500; i++) begin
      pri_cfg = 1'($urandom_range(0, 1));
      v.hsel  = ($urandom_range(0, 9) != 0);
      v.trans = 2'($urandom_range(0, 3));
      v.addr  = $urandom();
      v.addr[1:0] = 2'b00;
      v.burst = ($urandom_range(0, 2) == 0) ? I4 : BS;
      v.lock  = ($urandom_range(0, 5) == 0);
      v.gnt   = ($urandom_range(0, 9) < 6);
      v.ordy  = ($urandom_range(0, 3) != 0);
      v.oresp = ($urandom_range(0, 9) == 0);
      v.hready = L;
      r = modelExpect(v);
      v.hready = r.e_hro;
      r = modelExpect(v);
      applyStimulus(r);
      #2;
      checkOutput($sformatf("rand%0d", i), r);
      modelStep(r);
      @(posedge HCLK);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
